// File: rtl/mem_access_stage.sv
// MEM stage: drives a variable-latency req/ack data port for loads and stores,
// stalls upstream while an access is outstanding, and registers MEM/WB results.

module mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] IDX = LANE[1:0];

  // Narrow stores replicate the low byte/halfword into every lane; be picks the live ones.
  always_comb begin
    be    = 1'b1;
    wbyte = data[8*LANE +: 8];
    case (size)
      2'd0: begin
        be    = (off == IDX);
        wbyte = data[7:0];
      end
      2'd1: begin
        be    = (off[1] == IDX[1]);
        wbyte = data[8*(LANE%2) +: 8];
      end
      default: ;
    endcase
  end
endmodule

module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] VALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        Stall_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] VALUResult_o,
  output logic [31:0] ReadData_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        err_o
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  state_t   state, state_nxt;
  mem_req_t req_d, req_q;
  logic [7:0]  cnt, cnt_inc;
  logic        timeout_hit;
  logic [2:0]  funct3, req_f3;
  logic [1:0]  off, size, req_off;
  logic        mem_op, legal, aligned, issue;
  logic        abort;
  logic [31:0] rd_cap;
  logic        stall_raw, wb_load, err_nxt;
  logic [NUM_LANES-1:0]       lane_be;
  logic [NUM_LANES-1:0][7:0]  lane_wd;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {o, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  assign funct3 = instr_i[14:12];
  assign size   = funct3[1:0];
  assign off    = ALUResult_i[1:0];

  always_comb begin
    mem_op = MemRead_i | MemWrite_i;
    if (MemWrite_i) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else            legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~off[0];
      2'd2:    aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
    issue = mem_op & legal & aligned;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mem_access_lane #(.LANE(l)) u_lane (
      .off  (off),
      .size (size),
      .data (RDData_i),
      .be   (lane_be[l]),
      .wbyte(lane_wd[l])
    );
  end

  assign req_d.we    = MemWrite_i;
  assign req_d.addr  = {ALUResult_i[31:2], 2'b00};
  assign req_d.be    = lane_be;
  assign req_d.wdata = lane_wd;

  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_be_o    = req_q.be;
  assign mem_wdata_o = req_q.wdata;

  assign cnt_inc     = cnt + 8'd1;
  assign timeout_hit = (cnt_inc == TIMEOUT[7:0]);

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    wb_load   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        stall_raw = issue;
        wb_load   = ~issue;
        err_nxt   = mem_op & ~issue;
        if (issue) state_nxt = WAIT;
      end
      WAIT: begin
        stall_raw = 1'b1;
        if (mem_ack_i || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        wb_load   = 1'b1;
        err_nxt   = abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate with reset so upstream is never held while the stage is in reset.
  assign Stall_o = start_i & stall_raw;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      req_q        <= '0;
      mem_req_o    <= 1'b0;
      cnt          <= '0;
      abort        <= 1'b0;
      req_f3       <= '0;
      req_off      <= '0;
      rd_cap       <= '0;
      pc_o         <= '0;
      instr_o      <= '0;
      ALUResult_o  <= '0;
      VALUResult_o <= '0;
      ReadData_o   <= '0;
      RDaddr_o     <= '0;
      RegWrite_o   <= 1'b0;
      MemToReg_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o      <= err_nxt;
      RegWrite_o <= wb_load & ~err_nxt & RegWrite_i;
      MemToReg_o <= wb_load & ~err_nxt & MemToReg_i;
      // Data fields hold across bubbles so the MEM/WB contents stay deterministic.
      if (wb_load) begin
        pc_o         <= pc_i;
        instr_o      <= instr_i;
        ALUResult_o  <= ALUResult_i;
        VALUResult_o <= VALUResult_i;
        RDaddr_o     <= RDaddr_i;
        ReadData_o   <= (state == DONE && !abort) ? rd_cap : '0;
      end
      case (state)
        IDLE: if (issue) begin
          req_q     <= req_d;
          mem_req_o <= 1'b1;
          cnt       <= '0;
          abort     <= 1'b0;
          req_f3    <= funct3;
          req_off   <= off;
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            rd_cap    <= req_q.we ? '0 : fmt_load(req_f3, req_off, mem_rdata_i);
          end else if (timeout_hit) begin
            mem_req_o <= 1'b0;
            abort     <= 1'b1;
            rd_cap    <= '0;
          end
        end
        DONE:    cnt <= '0;
        default: ;
      endcase
    end
  end
endmodule
